// File: rtl/arc4_crack_sched.sv
// Schedules init/ksa/prga for each candidate key in a strided range and stops on found/exhaust/abort/timeout.
// Latency: 3 handshaked phases plus one EVAL cycle per key; backpressure: each phase waits on its sub-block rdy, and start is taken only while rdy.
module arc4_crack_sched #(
  parameter logic [23:0] KEY_FIRST  = 24'h000000,
  parameter logic [23:0] KEY_LAST   = 24'hFFFFFF,
  parameter logic [23:0] KEY_STRIDE = 24'd1,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        rdy,
  input  logic        init_rdy,
  input  logic        ksa_rdy,
  input  logic        prga_rdy,
  output logic        init_en,
  output logic        ksa_en,
  output logic        prga_en,
  input  logic        pt_ok,
  output logic [1:0]  mem_sel,
  output logic [23:0] key,
  output logic        found,
  output logic        done,
  output logic        err,
  output logic [23:0] attempts
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, I_EN, I_WAIT, K_EN, K_WAIT, P_EN, P_WAIT, EVAL,
    FOUND, EXHAUST, ABORTED, ERROR
  } state_t;

  state_t          state, state_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic            abort_q;
  logic            pt_ok_q;
  logic            start_acc, key_adv, att_inc, pt_ld, wd_clr, wd_inc;
  logic            abort_now, wd_first, wd_expired;
  logic [24:0]     key_sum;

  // 25-bit sum so a step past 24'hFFFFFF shows up as exhaustion, never a wrap
  assign key_sum    = {1'b0, key} + {1'b0, KEY_STRIDE};
  assign abort_now  = abort | abort_q;
  assign wd_first   = (wd_cnt == '0);
  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    done      = 1'b0;
    found     = 1'b0;
    err       = 1'b0;
    init_en   = 1'b0;
    ksa_en    = 1'b0;
    prga_en   = 1'b0;
    mem_sel   = 2'd0;
    start_acc = 1'b0;
    key_adv   = 1'b0;
    att_inc   = 1'b0;
    pt_ld     = 1'b0;
    wd_clr    = 1'b0;
    wd_inc    = 1'b0;
    case (state)
      IDLE, FOUND, EXHAUST, ABORTED, ERROR: begin
        rdy   = 1'b1;
        done  = (state != IDLE);
        found = (state == FOUND);
        err   = (state == ERROR);
        if (start) begin
          start_acc = 1'b1;
          state_nxt = abort ? ABORTED : I_EN;
        end
      end
      I_EN: begin
        mem_sel = 2'd1;
        if (init_rdy) begin
          init_en   = 1'b1;
          wd_clr    = 1'b1;
          state_nxt = I_WAIT;
        end
      end
      // first wait cycle ignores rdy: the sub-block drops it one cycle after en
      I_WAIT: begin
        mem_sel = 2'd1;
        wd_inc  = 1'b1;
        if (!wd_first && init_rdy) state_nxt = abort_now ? ABORTED : K_EN;
        else if (wd_expired)       state_nxt = ERROR;
      end
      K_EN: begin
        mem_sel = 2'd2;
        if (ksa_rdy) begin
          ksa_en    = 1'b1;
          wd_clr    = 1'b1;
          state_nxt = K_WAIT;
        end
      end
      K_WAIT: begin
        mem_sel = 2'd2;
        wd_inc  = 1'b1;
        if (!wd_first && ksa_rdy) state_nxt = abort_now ? ABORTED : P_EN;
        else if (wd_expired)      state_nxt = ERROR;
      end
      P_EN: begin
        mem_sel = 2'd3;
        if (prga_rdy) begin
          prga_en   = 1'b1;
          wd_clr    = 1'b1;
          state_nxt = P_WAIT;
        end
      end
      P_WAIT: begin
        mem_sel = 2'd3;
        wd_inc  = 1'b1;
        if (!wd_first && prga_rdy) begin
          pt_ld     = 1'b1;
          state_nxt = EVAL;
        end else if (wd_expired) begin
          state_nxt = ERROR;
        end
      end
      // a found key beats abort; abort only matters if another key would start
      EVAL: begin
        att_inc = 1'b1;
        if (pt_ok_q)                           state_nxt = FOUND;
        else if (key_sum > {1'b0, KEY_LAST})   state_nxt = EXHAUST;
        else if (abort_now)                    state_nxt = ABORTED;
        else begin
          key_adv   = 1'b1;
          state_nxt = I_EN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key      <= KEY_FIRST;
      attempts <= '0;
      abort_q  <= 1'b0;
      pt_ok_q  <= 1'b0;
      wd_cnt   <= '0;
    end else begin
      if (start_acc) begin
        key      <= KEY_FIRST;
        attempts <= '0;
      end else begin
        if (key_adv) key <= key_sum[23:0];
        if (att_inc && attempts != 24'hFFFFFF) attempts <= attempts + 24'd1;
      end
      if (start_acc)          abort_q <= 1'b0;
      else if (abort && !rdy) abort_q <= 1'b1;
      if (pt_ld) pt_ok_q <= pt_ok;
      if (wd_clr)      wd_cnt <= '0;
      else if (wd_inc) wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

endmodule

// File: tb/tb_arc4_crack_sched.sv
// Bench for arc4_crack_sched: three parameterisations driven by behavioural sub-block models
// with random latencies; results are scored against a plain key-walk reference.
module tb_arc4_crack_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start [3], abort [3], init_rdy [3], ksa_rdy [3], prga_rdy [3], pt_ok [3];
  logic rdy [3], init_en [3], ksa_en [3], prga_en [3], found [3], done [3], err [3];
  logic [1:0]  mem_sel [3];
  logic [23:0] key [3], attempts [3];

  int          cnt [3][3];
  logic        pend [3][3];
  logic        stall [3][3];
  logic [23:0] tgt [3];
  logic        f0 [3];
  logic        ptres [3];

  int          n_ien [3], n_ken [3], n_pen [3], n_bad [3];
  logic [23:0] tried [3][256];
  int          n_chk = 0;
  int          n_pass = 0;

  logic [23:0] exp_list [64];
  int          exp_n;
  logic        exp_fnd;
  logic [23:0] exp_key;

  always #5 clk = ~clk;

  arc4_crack_sched u_a (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .rdy(rdy[0]),
    .init_rdy(init_rdy[0]), .ksa_rdy(ksa_rdy[0]), .prga_rdy(prga_rdy[0]),
    .init_en(init_en[0]), .ksa_en(ksa_en[0]), .prga_en(prga_en[0]), .pt_ok(pt_ok[0]),
    .mem_sel(mem_sel[0]), .key(key[0]), .found(found[0]), .done(done[0]), .err(err[0]),
    .attempts(attempts[0]));

  arc4_crack_sched #(.KEY_FIRST(24'hFFFFFC), .TIMEOUT(16)) u_b (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .rdy(rdy[1]),
    .init_rdy(init_rdy[1]), .ksa_rdy(ksa_rdy[1]), .prga_rdy(prga_rdy[1]),
    .init_en(init_en[1]), .ksa_en(ksa_en[1]), .prga_en(prga_en[1]), .pt_ok(pt_ok[1]),
    .mem_sel(mem_sel[1]), .key(key[1]), .found(found[1]), .done(done[1]), .err(err[1]),
    .attempts(attempts[1]));

  arc4_crack_sched #(.KEY_FIRST(24'h000001), .KEY_STRIDE(24'd2)) u_c (
    .clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]), .rdy(rdy[2]),
    .init_rdy(init_rdy[2]), .ksa_rdy(ksa_rdy[2]), .prga_rdy(prga_rdy[2]),
    .init_en(init_en[2]), .ksa_en(ksa_en[2]), .prga_en(prga_en[2]), .pt_ok(pt_ok[2]),
    .mem_sel(mem_sel[2]), .key(key[2]), .found(found[2]), .done(done[2]), .err(err[2]),
    .attempts(attempts[2]));

  function automatic logic [23:0] kfirst(input int d);
    return (d == 1) ? 24'hFFFFFC : ((d == 2) ? 24'h000001 : 24'h000000);
  endfunction

  function automatic logic [23:0] kstride(input int d);
    return (d == 2) ? 24'd2 : 24'd1;
  endfunction

  function automatic logic en_of(input int d, input int j);
    case (j)
      0:       return init_en[d];
      1:       return ksa_en[d];
      default: return prga_en[d];
    endcase
  endfunction

  // sub-block model: rdy stays high one cycle after en, then low for a random latency
  always_comb begin
    for (int d = 0; d < 3; d++) begin
      init_rdy[d] = (cnt[d][0] == 0);
      ksa_rdy[d]  = (cnt[d][1] == 0);
      prga_rdy[d] = (cnt[d][2] == 0);
      pt_ok[d]    = ptres[d];
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      for (int j = 0; j < 3; j++) begin
        if (rst) begin
          cnt[d][j]  <= 0;
          pend[d][j] <= 1'b0;
        end else if (en_of(d, j)) begin
          pend[d][j] <= 1'b1;
        end else if (pend[d][j]) begin
          pend[d][j] <= 1'b0;
          cnt[d][j]  <= stall[d][j] ? 1000000 : int'($urandom_range(1, 5));
        end else if (cnt[d][j] > 0) begin
          cnt[d][j] <= cnt[d][j] - 1;
        end
      end
      if (rst)             ptres[d] <= 1'b0;
      else if (prga_en[d]) ptres[d] <= !f0[d] && (key[d] == tgt[d]);
    end
  end

  // monitor: en pulse counts, keys at each init_en, one-hot en and mem_sel ownership
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (init_en[d]) begin
        tried[d][n_ien[d] % 256] = key[d];
        n_ien[d]++;
      end
      if (ksa_en[d])  n_ken[d]++;
      if (prga_en[d]) n_pen[d]++;
      if (int'(init_en[d]) + int'(ksa_en[d]) + int'(prga_en[d]) > 1) n_bad[d]++;
      for (int j = 0; j < 3; j++)
        if (!rst && !done[d] && (pend[d][j] || cnt[d][j] != 0) && mem_sel[d] != 2'(j + 1))
          n_bad[d]++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_pulse(input int d);
    tick();
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget, output bit ok);
    int n = 0;
    while (!done[d] && n < budget) begin
      tick();
      n++;
    end
    ok = done[d];
  endtask

  task automatic model_search(input int d, input logic [23:0] t, input logic force0);
    logic [24:0] k;
    k       = {1'b0, kfirst(d)};
    exp_n   = 0;
    exp_fnd = 1'b0;
    exp_key = k[23:0];
    while (k <= 25'h0FFFFFF && exp_n < 64 && !exp_fnd) begin
      exp_list[exp_n] = k[23:0];
      exp_n++;
      exp_key = k[23:0];
      if (!force0 && k[23:0] == t) exp_fnd = 1'b1;
      k = k + {1'b0, kstride(d)};
    end
  endtask

  task automatic search_and_score(input int d, input logic [23:0] t, input logic force0,
                                  input bit poke, input string tag);
    int bi, bk, bp, bb, mis, n;
    bit ok;
    tgt[d] = t;
    f0[d]  = force0;
    model_search(d, t, force0);
    bi = n_ien[d]; bk = n_ken[d]; bp = n_pen[d]; bb = n_bad[d];
    start_pulse(d);
    if (poke) begin
      n = 0;
      while (n_pen[d] == bp && n < 2000) begin tick(); n++; end
      start_pulse(d);
    end
    wait_done(d, 5000, ok);
    mis = 0;
    for (int i = 0; i < exp_n; i++)
      if (i < n_ien[d] - bi && tried[d][(bi + i) % 256] !== exp_list[i]) mis++;
    n_chk++; if (ok !== 1'b1) $display("FAIL %s done_wait: done=%0b required 1", tag, done[d]); else n_pass++;
    n_chk++; if (found[d] !== exp_fnd) $display("FAIL %s found: got %0b required %0b", tag, found[d], exp_fnd); else n_pass++;
    n_chk++; if (key[d] !== exp_key) $display("FAIL %s key: got %h required %h", tag, key[d], exp_key); else n_pass++;
    n_chk++; if (attempts[d] !== 24'(exp_n)) $display("FAIL %s attempts: got %0d required %0d", tag, attempts[d], exp_n); else n_pass++;
    n_chk++; if (err[d] !== 1'b0) $display("FAIL %s err: got %0b required 0", tag, err[d]); else n_pass++;
    n_chk++; if (n_ien[d] - bi !== exp_n) $display("FAIL %s init_en_count: got %0d required %0d", tag, n_ien[d] - bi, exp_n); else n_pass++;
    n_chk++; if (n_ken[d] - bk !== exp_n) $display("FAIL %s ksa_en_count: got %0d required %0d", tag, n_ken[d] - bk, exp_n); else n_pass++;
    n_chk++; if (n_pen[d] - bp !== exp_n) $display("FAIL %s prga_en_count: got %0d required %0d", tag, n_pen[d] - bp, exp_n); else n_pass++;
    n_chk++; if (mis !== 0) $display("FAIL %s key_order: %0d keys out of order, required 0", tag, mis); else n_pass++;
    n_chk++; if (n_bad[d] - bb !== 0) $display("FAIL %s mem_sel_en: %0d violations, required 0", tag, n_bad[d] - bb); else n_pass++;
    n_chk++; if ({rdy[d], mem_sel[d]} !== 3'b100) $display("FAIL %s rdy_memsel: got %b required 100", tag, {rdy[d], mem_sel[d]}); else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if ({rdy[d], init_en[d], ksa_en[d], prga_en[d], mem_sel[d], found[d], done[d], err[d]} !== 9'b1_0000_0000)
        $display("FAIL reset_ctl[%0d]: got %b required 100000000", d,
                 {rdy[d], init_en[d], ksa_en[d], prga_en[d], mem_sel[d], found[d], done[d], err[d]});
      else n_pass++;
      n_chk++; if (key[d] !== kfirst(d)) $display("FAIL reset_key[%0d]: got %h required %h", d, key[d], kfirst(d)); else n_pass++;
      n_chk++; if (attempts[d] !== 24'd0) $display("FAIL reset_attempts[%0d]: got %0d required 0", d, attempts[d]); else n_pass++;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_known_key();
    search_and_score(0, 24'h000018, 1'b0, 1'b0, "known_key");
  endtask

  task automatic test_random_keys();
    for (int i = 0; i < 3; i++)
      search_and_score(0, 24'($urandom_range(0, 30)), 1'b0, 1'b0, "random_a");
    search_and_score(2, 24'($urandom_range(0, 10) * 2 + 1), 1'b0, 1'b0, "random_stride");
  endtask

  task automatic test_exhaust();
    search_and_score(1, 24'h000000, 1'b1, 1'b0, "exhaust");
  endtask

  task automatic test_stride();
    search_and_score(2, 24'h000007, 1'b0, 1'b0, "stride");
  endtask

  task automatic test_busy_start();
    search_and_score(2, 24'h000007, 1'b0, 1'b1, "busy_start");
  endtask

  task automatic test_abort();
    int bi, bk, bp, n;
    bit ok;
    tgt[0] = 24'h000100;
    f0[0]  = 1'b0;
    bi = n_ien[0]; bk = n_ken[0]; bp = n_pen[0];
    start_pulse(0);
    n = 0;
    while (n_ken[0] - bk < 2 && n < 2000) begin tick(); n++; end
    n_chk++; if (n_ken[0] - bk !== 2) $display("FAIL abort_reach_k_wait: ksa_en count %0d required 2", n_ken[0] - bk); else n_pass++;
    tick();
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    wait_done(0, 2000, ok);
    n_chk++; if ({ok, found[0], err[0]} !== 3'b100) $display("FAIL abort_status: done/found/err got %b required 100", {ok, found[0], err[0]}); else n_pass++;
    n_chk++; if (attempts[0] !== 24'd1) $display("FAIL abort_attempts: got %0d required 1", attempts[0]); else n_pass++;
    n_chk++; if (key[0] !== 24'd1) $display("FAIL abort_key: got %h required 000001", key[0]); else n_pass++;
    n_chk++;
    if ({n_ien[0] - bi, n_ken[0] - bk, n_pen[0] - bp} !== {32'd2, 32'd2, 32'd1})
      $display("FAIL abort_en_counts: got %0d/%0d/%0d required 2/2/1", n_ien[0] - bi, n_ken[0] - bk, n_pen[0] - bp);
    else n_pass++;
  endtask

  task automatic test_abort_found();
    int bp, n;
    bit ok;
    tgt[0] = 24'h000002;
    f0[0]  = 1'b0;
    bp = n_pen[0];
    start_pulse(0);
    n = 0;
    while (n_pen[0] - bp < 3 && n < 2000) begin tick(); n++; end
    n_chk++; if (n_pen[0] - bp !== 3) $display("FAIL abort_found_reach: prga_en count %0d required 3", n_pen[0] - bp); else n_pass++;
    tick();
    abort[0] = 1'b1;
    wait_done(0, 2000, ok);
    abort[0] = 1'b0;
    n_chk++; if ({ok, found[0]} !== 2'b11) $display("FAIL abort_found_status: done/found got %b required 11", {ok, found[0]}); else n_pass++;
    n_chk++; if (key[0] !== 24'd2) $display("FAIL abort_found_key: got %h required 000002", key[0]); else n_pass++;
    n_chk++; if (attempts[0] !== 24'd3) $display("FAIL abort_found_attempts: got %0d required 3", attempts[0]); else n_pass++;
    search_and_score(0, 24'h000001, 1'b0, 1'b0, "restart");
  endtask

  task automatic test_timeout();
    int bk, n;
    tgt[1]      = 24'h000000;
    f0[1]       = 1'b1;
    stall[1][1] = 1'b1;
    bk = n_ken[1];
    start_pulse(1);
    n = 0;
    while (n_ken[1] == bk && n < 2000) begin tick(); n++; end
    n_chk++; if (n_ken[1] - bk !== 1) $display("FAIL timeout_reach: ksa_en count %0d required 1", n_ken[1] - bk); else n_pass++;
    repeat (16) tick();
    n_chk++; if (err[1] !== 1'b0) $display("FAIL timeout_early: err=%0b at cycle 15 required 0", err[1]); else n_pass++;
    tick();
    n_chk++; if ({err[1], done[1], found[1]} !== 3'b110) $display("FAIL timeout_status: err/done/found got %b required 110", {err[1], done[1], found[1]}); else n_pass++;
    n_chk++; if (mem_sel[1] !== 2'd0) $display("FAIL timeout_mem_sel: got %0d required 0", mem_sel[1]); else n_pass++;
    stall[1][1] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int bp, n;
    tgt[0] = 24'h000032;
    f0[0]  = 1'b0;
    bp = n_pen[0];
    start_pulse(0);
    n = 0;
    while (n_pen[0] - bp < 2 && n < 2000) begin tick(); n++; end
    tick();
    tick();
    n_chk++; if (mem_sel[0] !== 2'd3) $display("FAIL reset_mid_phase: mem_sel got %0d required 3", mem_sel[0]); else n_pass++;
    rst = 1'b1;
    tick();
    n_chk++;
    if ({rdy[0], init_en[0], ksa_en[0], prga_en[0], mem_sel[0], found[0], done[0], err[0]} !== 9'b1_0000_0000)
      $display("FAIL reset_mid_ctl: got %b required 100000000",
               {rdy[0], init_en[0], ksa_en[0], prga_en[0], mem_sel[0], found[0], done[0], err[0]});
    else n_pass++;
    n_chk++; if (key[0] !== 24'd0) $display("FAIL reset_mid_key: got %h required 000000", key[0]); else n_pass++;
    n_chk++; if (attempts[0] !== 24'd0) $display("FAIL reset_mid_attempts: got %0d required 0", attempts[0]); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_invariants();
    int tot = n_bad[0] + n_bad[1] + n_bad[2];
    n_chk++; if (tot !== 0) $display("FAIL invariants: %0d mem_sel/en violations overall, required 0", tot); else n_pass++;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0;
      abort[d] = 1'b0;
      tgt[d]   = 24'h0;
      f0[d]    = 1'b0;
      for (int j = 0; j < 3; j++) stall[d][j] = 1'b0;
    end
    test_reset();
    test_known_key();
    test_random_keys();
    test_exhaust();
    test_stride();
    test_busy_start();
    test_abort();
    test_abort_found();
    test_timeout();
    test_reset_mid();
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
